// File: rtl/pnr_discriminator_pkg.sv
// Shared widths, FSM state encoding and popcount helper for the photon-number discriminator.
package pnr_pkg;
  localparam int ADC_W = 14;
  localparam int N_THR = 8;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {IDLE, DELAY, HOLDOFF} state_t;

  function automatic logic [3:0] popcount(input logic [N_THR-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < N_THR; k++) c = c + {3'b000, v[k]};
    return c;
  endfunction
endpackage

// File: rtl/pnr_discriminator_if.sv
// Bundle of ADC samples, configuration and result signals between the register block and the discriminator.
interface pnr_if;
  import pnr_pkg::*;

  // pnr_valid_o and trig_o are single-cycle pulses with no back-pressure; count/bits hold between results.
  logic signed [ADC_W-1:0] adc_a_i;
  logic signed [ADC_W-1:0] adc_b_i;
  logic                    trig_is_adc_a;
  logic signed [ADC_W-1:0] trig_threshold;
  logic [CNT_W-1:0]        trig_clearance;
  logic [CNT_W-1:0]        pnr_delay;
  logic [N_THR*ADC_W-1:0]  adc_photon_thr_i;
  logic                    trig_o;
  logic                    busy_o;
  logic                    pnr_valid_o;
  logic [3:0]              pnr_count_o;
  logic [N_THR-1:0]        pnr_bits_o;
  logic [CNT_W-1:0]        event_cnt_o;
  logic [CNT_W-1:0]        missed_cnt_o;
  state_t                  state;

  modport master (
    output adc_a_i, adc_b_i, trig_is_adc_a, trig_threshold, trig_clearance, pnr_delay, adc_photon_thr_i,
    input  trig_o, busy_o, pnr_valid_o, pnr_count_o, pnr_bits_o, event_cnt_o, missed_cnt_o, state
  );

  modport slave (
    input  adc_a_i, adc_b_i, trig_is_adc_a, trig_threshold, trig_clearance, pnr_delay, adc_photon_thr_i,
    output trig_o, busy_o, pnr_valid_o, pnr_count_o, pnr_bits_o, event_cnt_o, missed_cnt_o, state
  );
endinterface

// File: rtl/pnr_discriminator_threshold_bank.sv
// Signed comparison of one captured sample against N_THR thresholds, registered with its popcount.
module pnr_threshold_bank
  import pnr_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [ADC_W-1:0] sample,
  input  logic [N_THR*ADC_W-1:0]  thr,
  output logic                    valid,
  output logic [3:0]              count,
  output logic [N_THR-1:0]        bits
);
  logic [N_THR-1:0] hit;

  // Each threshold is judged on its own, so unsorted threshold sets are fine.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_THR; k++) hit[k] = sample >= $signed(thr[k*ADC_W +: ADC_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      count <= '0;
      bits  <= '0;
    end else begin
      valid <= sample_valid;
      if (sample_valid) begin
        bits  <= hit;
        count <= popcount(hit);
      end
    end
  end
endmodule

// File: rtl/pnr_discriminator.sv
// Trigger edge detection, delay/hold-off FSM, sample capture and event counters for photon-number discrimination.
module pnr_discriminator
  import pnr_pkg::*;
(
  input logic  clk_i,
  input logic  rst_i,
  pnr_if.slave bus
);
  logic signed [ADC_W-1:0] a_cur, b_cur, a_prev, b_prev;
  logic signed [ADC_W-1:0] trig_cur, trig_prev, pnr_sample, cap_sample;
  logic                    sel_cur, warm, arm, crossing, hit;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt, d_lat, c_lat, event_cnt, missed_cnt;
  logic [N_THR*ADC_W-1:0]  thr_lat;
  logic                    sel_lat, accept, capture, miss, trig_q, cap_valid;

  // arm stays low on the first cycle after reset (prev is still the reset value) and whenever the source flips.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_cur   <= '0;
      b_cur   <= '0;
      a_prev  <= '0;
      b_prev  <= '0;
      sel_cur <= 1'b0;
      warm    <= 1'b0;
      arm     <= 1'b0;
    end else begin
      a_cur   <= bus.adc_a_i;
      b_cur   <= bus.adc_b_i;
      a_prev  <= a_cur;
      b_prev  <= b_cur;
      sel_cur <= bus.trig_is_adc_a;
      warm    <= 1'b1;
      arm     <= warm && (bus.trig_is_adc_a == sel_cur);
    end
  end

  always_comb begin
    trig_cur   = sel_cur ? a_cur : b_cur;
    trig_prev  = sel_cur ? a_prev : b_prev;
    crossing   = (trig_prev < bus.trig_threshold) && (trig_cur >= bus.trig_threshold);
    hit        = crossing && arm;
    pnr_sample = ((state_q == IDLE) ? sel_cur : sel_lat) ? b_cur : a_cur;
  end

  // Zero delay captures straight from IDLE; otherwise cnt (0 on the cycle after the crossing) selects the sample.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    miss    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          accept = 1'b1;
          if (bus.pnr_delay == '0) begin
            capture = 1'b1;
            state_d = (bus.trig_clearance <= CNT_W'(1)) ? IDLE : HOLDOFF;
          end else begin
            state_d = DELAY;
          end
        end
      end
      DELAY: begin
        miss = hit;
        if (cnt == d_lat - CNT_W'(1)) begin
          capture = 1'b1;
          state_d = ({1'b0, c_lat} <= {1'b0, d_lat} + (CNT_W+1)'(1)) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        miss = hit;
        if (cnt >= c_lat - CNT_W'(2)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt        <= '0;
      d_lat      <= '0;
      c_lat      <= '0;
      sel_lat    <= 1'b0;
      thr_lat    <= '0;
      trig_q     <= 1'b0;
      cap_valid  <= 1'b0;
      cap_sample <= '0;
      event_cnt  <= '0;
      missed_cnt <= '0;
    end else begin
      state_q   <= state_d;
      trig_q    <= accept;
      cap_valid <= capture;
      if (capture) cap_sample <= pnr_sample;
      if (accept) begin
        cnt       <= '0;
        d_lat     <= bus.pnr_delay;
        c_lat     <= bus.trig_clearance;
        sel_lat   <= sel_cur;
        thr_lat   <= bus.adc_photon_thr_i;
        event_cnt <= event_cnt + CNT_W'(1);
      end else if (state_q != IDLE) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (miss) missed_cnt <= missed_cnt + CNT_W'(1);
    end
  end

  pnr_threshold_bank u_bank (
    .clk          (clk_i),
    .rst          (rst_i),
    .sample_valid (cap_valid),
    .sample       (cap_sample),
    .thr          (thr_lat),
    .valid        (bus.pnr_valid_o),
    .count        (bus.pnr_count_o),
    .bits         (bus.pnr_bits_o)
  );

  assign bus.trig_o       = trig_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.event_cnt_o  = event_cnt;
  assign bus.missed_cnt_o = missed_cnt;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_pnr_discriminator.sv
// Directed bench for pnr_discriminator: reset/arm, delay capture, clearance, latching, source switch and abort.
module tb_pnr_discriminator;
  import pnr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pnr_if bus();

  pnr_discriminator dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];
  int tv[N_THR];
  int t1, t2, t3, t4, t5, t6, t7, s0, r0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_result(input string tag);
    logic [11:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(bus.pnr_valid_o), 32'd1);
    check({tag, "_count"}, 32'(bus.pnr_count_o), 32'(e[11:8]));
    check({tag, "_bits"},  32'(bus.pnr_bits_o),  32'(e[7:0]));
  endtask

  // A rising crossing on channel A appears in the DUT's registered stage at cycle t.
  task automatic edge_a(input int t);
    step_to(t - 2);
    bus.adc_a_i = '0;
    step_to(t - 1);
    bus.adc_a_i = 14'sd200;
  endtask

  function automatic logic [N_THR*ADC_W-1:0] thr_pack(input int t[N_THR]);
    logic [N_THR*ADC_W-1:0] v;
    logic [31:0] w;
    v = '0;
    for (int k = 0; k < N_THR; k++) begin
      w = t[k];
      v[k*ADC_W +: ADC_W] = w[ADC_W-1:0];
    end
    return v;
  endfunction

  task automatic set_thr_lin();
    for (int k = 0; k < N_THR; k++) tv[k] = (k + 1) * 500;
    bus.adc_photon_thr_i = thr_pack(tv);
  endtask

  initial begin
    bus.adc_a_i        = 14'sh1000;
    bus.adc_b_i        = '0;
    bus.trig_is_adc_a  = 1'b1;
    bus.trig_threshold = '0;
    bus.trig_clearance = 32'd50;
    bus.pnr_delay      = 32'd10;
    set_thr_lin();

    // Reset with channel A already high.
    step_to(3);
    check("rst_trig",   32'(bus.trig_o),       32'd0);
    check("rst_busy",   32'(bus.busy_o),       32'd0);
    check("rst_valid",  32'(bus.pnr_valid_o),  32'd0);
    check("rst_count",  32'(bus.pnr_count_o),  32'd0);
    check("rst_bits",   32'(bus.pnr_bits_o),   32'd0);
    check("rst_event",  32'(bus.event_cnt_o),  32'd0);
    check("rst_missed", 32'(bus.missed_cnt_o), 32'd0);
    check("rst_state",  32'(bus.state),        32'(IDLE));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arm_no_trig", 32'(bus.trig_o), 32'd0);
    end
    check("arm_event", 32'(bus.event_cnt_o), 32'd0);

    // Basic event: D=10, C=50, B=1800 at t+10 meets 500/1000/1500.
    bus.trig_threshold = 14'sd100;
    bus.adc_a_i = '0;
    t1 = 15;
    edge_a(t1);
    step_to(t1 + 1);
    check("basic_trig",  32'(bus.trig_o),      32'd1);
    check("basic_event", 32'(bus.event_cnt_o), 32'd1);
    check("basic_busy",  32'(bus.busy_o),      32'd1);
    step_to(t1 + 9);
    bus.adc_b_i = 14'sd1800;
    step_to(t1 + 10);
    bus.adc_b_i = '0;
    check("basic_state_delay", 32'(bus.state), 32'(DELAY));
    step_to(t1 + 11);
    check("basic_early_valid", 32'(bus.pnr_valid_o), 32'd0);
    exp_q.push_back({4'd3, 8'h07});
    step_to(t1 + 12);
    check_result("basic");

    // Crossing inside the clearance window is only counted as missed.
    step_to(t1 + 18);
    bus.adc_a_i = '0;
    step_to(t1 + 19);
    bus.adc_a_i = 14'sd200;
    step_to(t1 + 21);
    check("clr_missed",     32'(bus.missed_cnt_o), 32'd1);
    check("clr_no_trig",    32'(bus.trig_o),       32'd0);
    check("clr_hold_count", 32'(bus.pnr_count_o),  32'd3);
    check("clr_hold_valid", 32'(bus.pnr_valid_o),  32'd0);
    step_to(t1 + 48);
    bus.adc_a_i = '0;
    step_to(t1 + 49);
    check("clr_busy_end", 32'(bus.busy_o), 32'd1);
    bus.adc_a_i = 14'sd200;
    step_to(t1 + 50);
    check("clr_idle", 32'(bus.busy_o), 32'd0);
    step_to(t1 + 51);
    check("clr_trig2",  32'(bus.trig_o),      32'd1);
    check("clr_event2", 32'(bus.event_cnt_o), 32'd2);
    exp_q.push_back({4'd0, 8'h00});
    step_to(t1 + 62);
    check_result("clr_zero");

    // D=0 and C=1: capture the crossing-cycle sample, no hold-off.
    bus.pnr_delay = 32'd0;
    bus.trig_clearance = 32'd1;
    t2 = t1 + 105;
    edge_a(t2);
    bus.adc_b_i = 14'sd4000;
    step_to(t2);
    bus.adc_b_i = '0;
    step_to(t2 + 1);
    check("d0_trig",  32'(bus.trig_o),      32'd1);
    check("d0_busy",  32'(bus.busy_o),      32'd0);
    check("d0_event", 32'(bus.event_cnt_o), 32'd3);
    exp_q.push_back({4'd8, 8'hFF});
    step_to(t2 + 2);
    check_result("d0");

    // Boundary thresholds: most positive and most negative.
    tv = '{8191, -8192, 8191, 8191, 8191, 8191, 8191, 8191};
    bus.adc_photon_thr_i = thr_pack(tv);
    t3 = t2 + 6;
    edge_a(t3);
    bus.adc_b_i = 14'sh1FFE;
    step_to(t3);
    bus.adc_b_i = '0;
    exp_q.push_back({4'd1, 8'h02});
    step_to(t3 + 2);
    check_result("max_minus1");
    t4 = t3 + 6;
    edge_a(t4);
    bus.adc_b_i = 14'sh1FFF;
    step_to(t4);
    bus.adc_b_i = '0;
    exp_q.push_back({4'd8, 8'hFF});
    step_to(t4 + 2);
    check_result("max_equal");
    t5 = t4 + 6;
    edge_a(t5);
    bus.adc_b_i = 14'sh2000;
    step_to(t5);
    bus.adc_b_i = '0;
    exp_q.push_back({4'd1, 8'h02});
    step_to(t5 + 2);
    check_result("most_negative");

    // Unsorted thresholds give independent bits and a popcount.
    tv = '{3000, 100, 2000, -50, 1500, 4000, 0, 1501};
    bus.adc_photon_thr_i = thr_pack(tv);
    t6 = t5 + 6;
    edge_a(t6);
    bus.adc_b_i = 14'sd1500;
    step_to(t6);
    bus.adc_b_i = '0;
    exp_q.push_back({4'd4, 8'h5A});
    step_to(t6 + 2);
    check_result("unsorted");
    check("unsorted_event", 32'(bus.event_cnt_o), 32'd7);

    // C=3 < D+1: retrigger at t+12; config changed at t+5 must not touch the running event.
    bus.pnr_delay = 32'd10;
    bus.trig_clearance = 32'd3;
    set_thr_lin();
    t7 = t6 + 6;
    edge_a(t7);
    step_to(t7 + 1);
    check("latch_trig",  32'(bus.trig_o),      32'd1);
    check("latch_event", 32'(bus.event_cnt_o), 32'd8);
    step_to(t7 + 5);
    bus.pnr_delay = 32'd2;
    bus.trig_clearance = 32'd100;
    for (int k = 0; k < N_THR; k++) tv[k] = -8192;
    bus.adc_photon_thr_i = thr_pack(tv);
    step_to(t7 + 9);
    bus.adc_b_i = 14'sd1800;
    step_to(t7 + 10);
    bus.adc_b_i = '0;
    bus.adc_a_i = '0;
    step_to(t7 + 11);
    check("latch_idle", 32'(bus.busy_o), 32'd0);
    bus.adc_a_i = 14'sd200;
    exp_q.push_back({4'd3, 8'h07});
    step_to(t7 + 12);
    check_result("latch_first");
    step_to(t7 + 13);
    check("latch_retrig", 32'(bus.trig_o),      32'd1);
    check("latch_event2", 32'(bus.event_cnt_o), 32'd9);
    exp_q.push_back({4'd8, 8'hFF});
    step_to(t7 + 16);
    check_result("latch_second");
    check("latch_missed", 32'(bus.missed_cnt_o), 32'd1);

    // Source switch while B rises: the edge must be suppressed.
    s0 = t7 + 115;
    step_to(s0);
    bus.adc_b_i = 14'sd500;
    bus.trig_is_adc_a = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step_to(s0 + i);
      check("switch_no_trig", 32'(bus.trig_o), 32'd0);
    end
    check("switch_event",  32'(bus.event_cnt_o),  32'd9);
    check("switch_missed", 32'(bus.missed_cnt_o), 32'd1);
    step_to(s0 + 5);
    set_thr_lin();
    bus.pnr_delay = 32'd0;
    bus.trig_clearance = 32'd1;
    bus.adc_a_i = 14'sd2600;
    step_to(s0 + 6);
    bus.adc_b_i = '0;
    step_to(s0 + 7);
    bus.adc_b_i = 14'sd500;
    step_to(s0 + 9);
    check("b_trig",  32'(bus.trig_o),      32'd1);
    check("b_event", 32'(bus.event_cnt_o), 32'd10);
    exp_q.push_back({4'd5, 8'h1F});
    step_to(s0 + 10);
    check_result("b_sample_a");

    // Reset in the middle of DELAY aborts the event.
    bus.pnr_delay = 32'd10;
    bus.trig_clearance = 32'd50;
    r0 = s0 + 20;
    step_to(r0 - 2);
    bus.adc_b_i = '0;
    step_to(r0 - 1);
    bus.adc_b_i = 14'sd500;
    step_to(r0 + 1);
    check("abort_trig", 32'(bus.trig_o), 32'd1);
    check("abort_busy", 32'(bus.busy_o), 32'd1);
    step_to(r0 + 5);
    rst = 1'b1;
    step_to(r0 + 6);
    rst = 1'b0;
    check("abort_state",  32'(bus.state),        32'(IDLE));
    check("abort_busy0",  32'(bus.busy_o),       32'd0);
    check("abort_event",  32'(bus.event_cnt_o),  32'd0);
    check("abort_missed", 32'(bus.missed_cnt_o), 32'd0);
    for (int i = 7; i <= 14; i++) begin
      step_to(r0 + i);
      check("abort_no_valid", 32'(bus.pnr_valid_o), 32'd0);
      check("abort_no_trig",  32'(bus.trig_o),      32'd0);
    end
    check("abort_final_event", 32'(bus.event_cnt_o), 32'd0);
    check("abort_final_busy",  32'(bus.busy_o),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
